// File: rtl/soc_pkg.sv
// Shared types and constants for the soc Wishbone fabric: arbiter state encoding,
// request/response bundles and the round-robin pick rule.
package soc_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  localparam int unsigned WB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic                 ack;
    logic                 err;
    logic [WB_DATA_W-1:0] dat;
  } wb_rsp_t;

  // Round-robin choice at an arbitration point; last = 1 means M1 won the previous grant.
  function automatic wb_arb_state_e wb_arb_pick(input logic cyc0, input logic cyc1,
                                                input logic last);
    wb_arb_state_e pick;
    if (cyc0 && cyc1) pick = last ? GRANT_M0 : GRANT_M1;
    else if (cyc0)    pick = GRANT_M0;
    else if (cyc1)    pick = GRANT_M1;
    else              pick = IDLE;
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Per-transfer watchdog: counts stalled strobe cycles on the slave bus and
// produces a one-cycle fire pulse when the count reaches TIMEOUT_CYCLES.
module wb_arb_timeout
  import soc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cyc,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic restart,
  output logic fire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;
  logic        stalled;

  assign stalled = cyc & stb & ~ack & ~err;

  // A genuine ack in the firing cycle wins; the transfer completed normally.
  assign fire = cyc & stb & ~ack & (count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (fire || ack || err || !stb || restart) begin
      count <= '0;
    end else if (stalled) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B4 classic arbiter: round-robin grant locked for
// the holder's cyc, combinational request/response muxing and a stall watchdog.
module wb_arbiter_2m
  import soc_pkg::*;
#(
  parameter int          ADDR_W         = WB_ADDR_W,
  parameter int          DATA_W         = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_dat_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_dat_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic [DATA_W-1:0]   s_dat_i,

  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  localparam int SEL_W = DATA_W / 8;

  wb_arb_state_e state, state_next;
  logic          last, last_next;
  logic          rearb;
  logic          gnt0, gnt1;
  logic          holder_change;
  logic          wd_fire;

  // Reset leaves last = 1 so M0 takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    last_next  = last;
    rearb      = 1'b1;
    case (state)
      GRANT_M0: rearb = ~m0_cyc_i;
      GRANT_M1: rearb = ~m1_cyc_i;
      default:  rearb = 1'b1;
    endcase
    if (rearb) begin
      state_next = wb_arb_pick(m0_cyc_i, m1_cyc_i, last);
      if (state_next == GRANT_M0)      last_next = 1'b0;
      else if (state_next == GRANT_M1) last_next = 1'b1;
    end
  end

  assign gnt0          = (state == GRANT_M0);
  assign gnt1          = (state == GRANT_M1);
  assign grant_o       = {gnt1, gnt0};
  assign holder_change = (state_next != state);

  // Request path: AND-OR mux on the registered grant, all zero when idle.
  assign s_cyc_o = (m0_cyc_i & gnt0) | (m1_cyc_i & gnt1);
  assign s_stb_o = (m0_stb_i & gnt0) | (m1_stb_i & gnt1);
  assign s_we_o  = (m0_we_i  & gnt0) | (m1_we_i  & gnt1);
  assign s_sel_o = ({SEL_W{gnt0}}  & m0_sel_i) | ({SEL_W{gnt1}}  & m1_sel_i);
  assign s_adr_o = ({ADDR_W{gnt0}} & m0_adr_i) | ({ADDR_W{gnt1}} & m1_adr_i);
  assign s_dat_o = ({DATA_W{gnt0}} & m0_dat_i) | ({DATA_W{gnt1}} & m1_dat_i);

  // Response path: only the holder sees the slave; the watchdog error is merged in.
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | wd_fire);
  assign m0_dat_o = {DATA_W{gnt0}} & s_dat_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | wd_fire);
  assign m1_dat_o = {DATA_W{gnt1}} & s_dat_i;

  assign timeout_o = wd_fire;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .cyc     (s_cyc_o),
    .stb     (s_stb_o),
    .ack     (s_ack_i),
    .err     (s_err_i),
    .restart (holder_change),
    .fire    (wd_fire)
  );

  grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_o));
  single_ack:   assert property (@(posedge clk_i) disable iff (!rst_ni) !(m0_ack_o && m1_ack_o));

endmodule
